// File: rtl/error_latch_bank.sv
// Multi-channel fault latch: consecutive-sample filter per channel, masking,
// acknowledge-based clearing and first-fault capture driving an alarm lamp.
module error_latch_bank #(
  parameter int N_CH             = 8,
  parameter int FILT_CYC         = 4,
  parameter int LA_on_when_Reset = 0,
  localparam int FF_W            = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CNT_W           = (FILT_CYC > 1) ? $clog2(FILT_CYC + 1) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] in,
  input  logic [N_CH-1:0] mask,
  input  logic            clear,
  input  logic            LA_Test,
  output logic [N_CH-1:0] out,
  output logic            LA,
  output logic [FF_W-1:0] first_fault,
  output logic            first_valid
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYC - 1);

  logic [N_CH-1:0] r_out;
  logic [N_CH-1:0] w_qual;
  logic [N_CH-1:0] w_set;
  logic [N_CH-1:0] w_clr;
  logic [N_CH-1:0] w_out_next;
  logic [FF_W-1:0] r_first_fault;
  logic            r_first_valid;
  logic [FF_W-1:0] w_lowest_set;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;

      // A sample only counts while the channel is faulty, unmasked and not yet latched.
      assign w_qual[gi] = ~in[gi] & ~mask[gi] & ~r_out[gi];
      assign w_set[gi]  = w_qual[gi] & (r_cnt == CNT_LAST);
      assign w_clr[gi]  = clear & r_out[gi] & in[gi];

      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
        end else if (w_qual[gi] && (r_cnt != CNT_LAST)) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cnt <= '0;
        end
      end
    end
  endgenerate

  assign w_out_next = (r_out | w_set) & ~w_clr;

  always_comb begin
    w_lowest_set = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_set[i]) begin
        w_lowest_set = FF_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out         <= '0;
      r_first_valid <= 1'b0;
      r_first_fault <= '0;
    end else begin
      r_out <= w_out_next;
      if (w_out_next == '0) begin
        r_first_valid <= 1'b0;
      end else if ((|w_set) && (!r_first_valid || ((r_out & ~w_clr) == '0))) begin
        // Capture also when clear empties the old latches on the same edge a new one sets.
        r_first_valid <= 1'b1;
        r_first_fault <= w_lowest_set;
      end
    end
  end

  assign out         = r_out;
  assign first_fault = r_first_fault;
  assign first_valid = r_first_valid;
  assign LA          = (|r_out) | LA_Test | ((LA_on_when_Reset != 0) & reset);

endmodule

// File: tb/tb_error_latch_bank.sv
// Bench for error_latch_bank (4 channels, 3-sample filter): directed scenarios
// followed by random stimulus, all checked against a run-length reference model.
module tb_error_latch_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_s;
  logic [3:0] mask_s;
  logic       clear;
  logic       la_test;
  logic [3:0] out_s;
  logic       la;
  logic [1:0] first_fault;
  logic       first_valid;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: consecutive qualifying-sample run length per channel.
  int       m_run [4];
  bit [3:0] m_out;
  bit       m_fv;
  int       m_ff;

  error_latch_bank #(.N_CH(4), .FILT_CYC(3), .LA_on_when_Reset(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in_s),
    .mask       (mask_s),
    .clear      (clear),
    .LA_Test    (la_test),
    .out        (out_s),
    .LA         (la),
    .first_fault(first_fault),
    .first_valid(first_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    bit [3:0] set_v;
    bit [3:0] clr_v;
    bit [3:0] nxt;
    int       low;
    #1;
    check("LA_pre", {31'd0, la}, {31'd0, (|m_out) | la_test});
    set_v = '0;
    low = -1;
    for (int ch = 0; ch < 4; ch++) begin
      if (reset) begin
        m_run[ch] = 0;
      end else if (!in_s[ch] && !mask_s[ch] && !m_out[ch]) begin
        m_run[ch] = m_run[ch] + 1;
        if (m_run[ch] == 3) begin
          set_v[ch] = 1'b1;
          m_run[ch] = 0;
          if (low < 0) low = ch;
        end
      end else begin
        m_run[ch] = 0;
      end
    end
    clr_v = clear ? (m_out & in_s) : 4'b0;
    nxt = reset ? 4'b0 : ((m_out | set_v) & ~clr_v);
    if (reset) begin
      m_fv = 0;
      m_ff = 0;
    end else if (nxt == 0) begin
      m_fv = 0;
    end else if (set_v != 0 && (!m_fv || (m_out & ~clr_v) == 0)) begin
      m_fv = 1;
      m_ff = low;
    end
    m_out = nxt;
    @(posedge clk);
    #1;
    check("out", {28'd0, out_s}, {28'd0, m_out});
    check("first_valid", {31'd0, first_valid}, {31'd0, m_fv});
    if (m_fv) check("first_fault", {30'd0, first_fault}, m_ff);
    check("LA", {31'd0, la}, {31'd0, (|m_out) | la_test});
    $display("edge rst=%0b in=%b mask=%b clr=%0b -> out=%b fv=%0b ff=%0d LA=%0b",
             reset, in_s, mask_s, clear, out_s, first_valid, first_fault, la);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int ch = 0; ch < 4; ch++) m_run[ch] = 0;
    m_out = 0; m_fv = 0; m_ff = 0;
    reset = 1; in_s = 4'b1111; mask_s = 4'b0; clear = 0; la_test = 0;

    // Reset values and lamp test
    steps(2);
    check("rst_out", {28'd0, out_s}, 32'h0);
    check("rst_fv", {31'd0, first_valid}, 32'h0);
    check("rst_ff", {30'd0, first_fault}, 32'h0);
    check("rst_LA", {31'd0, la}, 32'h0);
    la_test = 1; #1;
    check("lamp_LA", {31'd0, la}, 32'h1);
    check("lamp_out", {28'd0, out_s}, 32'h0);
    la_test = 0; reset = 0;
    step();

    // Filter with a one-sample healthy glitch
    in_s = 4'b1011; steps(2);
    in_s = 4'b1111; step();
    in_s = 4'b1011; steps(2);
    check("filt_2nd", {28'd0, out_s}, 32'h0);
    step();
    check("filt_out", {28'd0, out_s}, 32'h4);
    check("filt_ff", {30'd0, first_fault}, 32'h2);
    check("filt_LA", {31'd0, la}, 32'h1);

    // Clear blocked while faulty, effective once healthy
    clear = 1; step(); clear = 0;
    check("hold_out", {28'd0, out_s}, 32'h4);
    in_s = 4'b1111; clear = 1; step(); clear = 0;
    check("clr_out", {28'd0, out_s}, 32'h0);
    check("clr_fv", {31'd0, first_valid}, 32'h0);
    check("clr_LA", {31'd0, la}, 32'h0);

    // Simultaneous faults, later fault keeps first index
    in_s = 4'b1001; steps(3);
    check("sim_out", {28'd0, out_s}, 32'h6);
    check("sim_ff", {30'd0, first_fault}, 32'h1);
    in_s = 4'b0001; steps(3);
    check("late_out", {28'd0, out_s}, 32'hE);
    check("late_ff", {30'd0, first_fault}, 32'h1);
    in_s = 4'b1111; clear = 1; step(); clear = 0;

    // Masking
    mask_s = 4'b0001; in_s = 4'b1110; steps(10);
    check("mask_out", {28'd0, out_s}, 32'h0);
    mask_s = 4'b0000; steps(3);
    check("unmask_out", {28'd0, out_s}, 32'h1);
    mask_s = 4'b0001; step();
    check("mask_latched", {28'd0, out_s}, 32'h1);
    mask_s = 4'b0000; in_s = 4'b1111; clear = 1; step(); clear = 0;

    // Clear on the same edge as a new latch
    in_s = 4'b1101; steps(3);
    in_s = 4'b0111; steps(2);
    clear = 1; step(); clear = 0;
    check("cs_out", {28'd0, out_s}, 32'h8);
    check("cs_ff", {30'd0, first_fault}, 32'h3);
    check("cs_fv", {31'd0, first_valid}, 32'h1);
    in_s = 4'b1111; clear = 1; step(); clear = 0;

    // Reset mid-count
    in_s = 4'b1110; steps(2);
    reset = 1; step(); reset = 0;
    steps(2);
    check("rmid_out", {28'd0, out_s}, 32'h0);
    step();
    check("rmid_latch", {28'd0, out_s}, 32'h1);

    // Random traffic with sticky per-channel faults
    for (int n = 0; n < 600; n++) begin
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(0, 5) == 0) in_s[ch] = ~in_s[ch];
      mask_s  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : mask_s;
      clear   = ($urandom_range(0, 4) == 0);
      la_test = ($urandom_range(0, 9) == 0);
      reset   = ($urandom_range(0, 60) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
